// File: rtl/ft_pkg.sv
// ft_pkg: shared types and constants for the fault-tolerant writeback voter.
//   ft_state_e  - recovery FSM encoding
//   vote_res_e  - result class from the majority voter
package ft_pkg;

   typedef enum logic [1:0] {
      FT_RUN     = 2'd0,
      FT_REQ     = 2'd1,
      FT_RECOVER = 2'd2
   } ft_state_e;

   typedef enum logic [1:0] {
      VOTE_OK        = 2'd0,
      VOTE_CORRECTED = 2'd1,
      VOTE_FAIL      = 2'd2
   } vote_res_e;

   localparam int unsigned FT_DMR_CORES = 2;
   localparam int unsigned FT_TMR_CORES = 3;

   function automatic logic ft_legal_num_cores(input int unsigned n);
      return (n == FT_DMR_CORES) || (n == FT_TMR_CORES);
   endfunction

endpackage

// File: rtl/ft_majority_voter.sv
// ft_majority_voter: combinational compare of NUM_CORES packed tuples.
//   tuples_i    in   NUM_CORES*TUPLE_W  core k at [k*TUPLE_W +: TUPLE_W]
//   vote_res_o  out  OK / CORRECTED / FAIL
//   sel_o       out  TUPLE_W   agreed (or majority) tuple
//   minority_o  out  NUM_CORES one-hot outvoted core, TMR corrections only
module ft_majority_voter
   import ft_pkg::*;
#(
   parameter int unsigned NUM_CORES = 3,
   parameter int unsigned TUPLE_W   = 38
) (
   input  logic [NUM_CORES*TUPLE_W-1:0] tuples_i,
   output vote_res_e                    vote_res_o,
   output logic [TUPLE_W-1:0]           sel_o,
   output logic [NUM_CORES-1:0]         minority_o
);

   if (NUM_CORES == FT_TMR_CORES) begin : g_tmr
      logic [TUPLE_W-1:0] t0, t1, t2;
      logic               e01, e02, e12;

      assign t0  = tuples_i[0*TUPLE_W +: TUPLE_W];
      assign t1  = tuples_i[1*TUPLE_W +: TUPLE_W];
      assign t2  = tuples_i[2*TUPLE_W +: TUPLE_W];
      assign e01 = (t0 == t1);
      assign e02 = (t0 == t2);
      assign e12 = (t1 == t2);

      always_comb begin
         vote_res_o = VOTE_FAIL;
         sel_o      = t0;
         minority_o = '0;
         if (e01 && e02) begin
            vote_res_o = VOTE_OK;
         end else if (e01) begin
            vote_res_o = VOTE_CORRECTED;
            minority_o = 3'b100;
         end else if (e02) begin
            vote_res_o = VOTE_CORRECTED;
            minority_o = 3'b010;
         end else if (e12) begin
            // core 0 outvoted: take the tuple from core 1
            vote_res_o = VOTE_CORRECTED;
            sel_o      = t1;
            minority_o = 3'b001;
         end
      end
   end else begin : g_dmr
      logic [TUPLE_W-1:0] t0, t1;

      assign t0         = tuples_i[0*TUPLE_W +: TUPLE_W];
      assign t1         = tuples_i[1*TUPLE_W +: TUPLE_W];
      assign sel_o      = t0;
      assign minority_o = '0;
      assign vote_res_o = (t0 == t1) ? VOTE_OK : VOTE_FAIL;
   end

endmodule

// File: rtl/ft_wb_voter.sv
// ft_wb_voter: DMR/TMR writeback voter between redundant cores and the
// shared register file. One-cycle registered output of the agreed tuple,
// saturating error/fault counters and a recovery request/ack handshake.
//   clk_i, rst_ni                      clock, synchronous active-low reset
//   valid_instr_i, we_i, addr_i, data_i  per-core writeback tuples
//   inject_i                           flips data bit 0 of core 0 before compare
//   clear_i                            zeroes all counters
//   recover_ack_i, recover_done_i      controller handshake
//   valid_o, we_o, addr_o, data_o      registered agreed tuple
//   error_o, faulty_o, uncorrectable_o one-cycle mismatch pulses
//   err_count_o                        saturating mismatch count
//   recover_req_o, halted_o            FSM status
//
// state      | meaning
// FT_RUN     | voting, outputs loaded from the cores
// FT_REQ     | recovery requested, waiting for recover_ack_i
// FT_RECOVER | controller resynchronising, waiting for recover_done_i
module ft_wb_voter
   import ft_pkg::*;
#(
   parameter int unsigned NUM_CORES       = 3,
   parameter int unsigned ADDR_WIDTH      = 5,
   parameter int unsigned DATA_WIDTH      = 32,
   parameter int unsigned CNT_WIDTH       = 8,
   parameter int unsigned FAULT_THRESHOLD = 3
) (
   input  logic                           clk_i,
   input  logic                           rst_ni,
   input  logic                           valid_instr_i,
   input  logic [NUM_CORES-1:0]           we_i,
   input  logic [NUM_CORES*ADDR_WIDTH-1:0] addr_i,
   input  logic [NUM_CORES*DATA_WIDTH-1:0] data_i,
   input  logic                           inject_i,
   input  logic                           clear_i,
   input  logic                           recover_ack_i,
   input  logic                           recover_done_i,
   output logic                           valid_o,
   output logic                           we_o,
   output logic [ADDR_WIDTH-1:0]          addr_o,
   output logic [DATA_WIDTH-1:0]          data_o,
   output logic                           error_o,
   output logic [NUM_CORES-1:0]           faulty_o,
   output logic                           uncorrectable_o,
   output logic [CNT_WIDTH-1:0]           err_count_o,
   output logic                           recover_req_o,
   output logic                           halted_o
);

   localparam int unsigned TUPLE_W = 1 + ADDR_WIDTH + DATA_WIDTH;
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
   localparam logic [CNT_WIDTH-1:0] THRESH  = CNT_WIDTH'(FAULT_THRESHOLD);

   if (!ft_legal_num_cores(NUM_CORES)) begin : g_bad_cores
      $error("ft_wb_voter: NUM_CORES must be 2 or 3");
   end
   if ((FAULT_THRESHOLD < 1) || (FAULT_THRESHOLD > (2**CNT_WIDTH) - 1)) begin : g_bad_thresh
      $error("ft_wb_voter: FAULT_THRESHOLD out of range for CNT_WIDTH");
   end

   logic [NUM_CORES*TUPLE_W-1:0] tuples;
   vote_res_e                    vote_res;
   logic [TUPLE_W-1:0]           sel_tuple;
   logic [NUM_CORES-1:0]         minority;

   // Tuple layout {we, addr, data}: bit 0 of core 0's tuple is its data bit 0.
   always_comb begin
      tuples = '0;
      for (int k = 0; k < NUM_CORES; k++) begin
         tuples[k*TUPLE_W +: TUPLE_W] = {we_i[k],
                                         addr_i[k*ADDR_WIDTH +: ADDR_WIDTH],
                                         data_i[k*DATA_WIDTH +: DATA_WIDTH]};
      end
      tuples[0] = tuples[0] ^ inject_i;
   end

   ft_majority_voter #(
      .NUM_CORES (NUM_CORES),
      .TUPLE_W   (TUPLE_W)
   ) u_voter (
      .tuples_i   (tuples),
      .vote_res_o (vote_res),
      .sel_o      (sel_tuple),
      .minority_o (minority)
   );

   ft_state_e               state_q, state_d;
   logic                    valid_q, valid_d;
   logic                    we_q, we_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [DATA_WIDTH-1:0]   data_q, data_d;
   logic                    error_q, error_d;
   logic                    unc_q, unc_d;
   logic [NUM_CORES-1:0]    faulty_q, faulty_d;
   logic [CNT_WIDTH-1:0]    err_cnt_q, err_cnt_d;
   logic [CNT_WIDTH-1:0]    fault_cnt_q [NUM_CORES];
   logic [CNT_WIDTH-1:0]    fault_cnt_d [NUM_CORES];
   logic                    sample;
   logic                    thresh_hit;

   always_comb begin
      state_d    = state_q;
      valid_d    = 1'b0;
      we_d       = we_q;
      addr_d     = addr_q;
      data_d     = data_q;
      error_d    = 1'b0;
      unc_d      = 1'b0;
      faulty_d   = '0;
      thresh_hit = 1'b0;
      sample     = valid_instr_i && (state_q == FT_RUN);

      // Clear applies first so a same-cycle mismatch lands on top of it.
      err_cnt_d = clear_i ? '0 : err_cnt_q;
      for (int k = 0; k < NUM_CORES; k++) begin
         fault_cnt_d[k] = clear_i ? '0 : fault_cnt_q[k];
      end

      if (sample) begin
         case (vote_res)
            VOTE_OK: begin
               valid_d                = 1'b1;
               {we_d, addr_d, data_d} = sel_tuple;
            end
            VOTE_CORRECTED: begin
               valid_d                = 1'b1;
               {we_d, addr_d, data_d} = sel_tuple;
               error_d                = 1'b1;
               faulty_d               = minority;
               for (int k = 0; k < NUM_CORES; k++) begin
                  if (minority[k] && (fault_cnt_d[k] != CNT_MAX)) begin
                     fault_cnt_d[k] = fault_cnt_d[k] + 1'b1;
                     if (fault_cnt_d[k] == THRESH) thresh_hit = 1'b1;
                  end
               end
            end
            default: begin
               error_d = 1'b1;
               unc_d   = 1'b1;
            end
         endcase
         if ((vote_res != VOTE_OK) && (err_cnt_d != CNT_MAX)) begin
            err_cnt_d = err_cnt_d + 1'b1;
         end
      end

      case (state_q)
         FT_RUN: begin
            if (sample && ((vote_res == VOTE_FAIL) || thresh_hit)) state_d = FT_REQ;
         end
         FT_REQ: begin
            if (recover_ack_i) state_d = FT_RECOVER;
         end
         FT_RECOVER: begin
            if (recover_done_i) begin
               state_d = FT_RUN;
               for (int k = 0; k < NUM_CORES; k++) fault_cnt_d[k] = '0;
            end
         end
         default: state_d = FT_RUN;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q   <= FT_RUN;
         valid_q   <= 1'b0;
         we_q      <= 1'b0;
         addr_q    <= '0;
         data_q    <= '0;
         error_q   <= 1'b0;
         unc_q     <= 1'b0;
         faulty_q  <= '0;
         err_cnt_q <= '0;
         for (int k = 0; k < NUM_CORES; k++) fault_cnt_q[k] <= '0;
      end else begin
         state_q   <= state_d;
         valid_q   <= valid_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         data_q    <= data_d;
         error_q   <= error_d;
         unc_q     <= unc_d;
         faulty_q  <= faulty_d;
         err_cnt_q <= err_cnt_d;
         for (int k = 0; k < NUM_CORES; k++) fault_cnt_q[k] <= fault_cnt_d[k];
      end
   end

   assign valid_o         = valid_q;
   assign we_o            = we_q;
   assign addr_o          = addr_q;
   assign data_o          = data_q;
   assign error_o         = error_q;
   assign uncorrectable_o = unc_q;
   assign faulty_o        = faulty_q;
   assign err_count_o     = err_cnt_q;
   assign recover_req_o   = (state_q == FT_REQ);
   assign halted_o        = (state_q != FT_RUN);

endmodule

// File: doc/ft_wb_voter.md
Name: ft_wb_voter

Overview:
- Parametrised successor to the lockstep writeback comparator.
- Compares the register-file writeback tuple {we, addr, data} from NUM_CORES redundant cores: DMR when NUM_CORES=2, TMR when NUM_CORES=3.
- Registers the agreed/majority result, counts per-core faults, and runs a request/acknowledge recovery handshake with the fault-tolerance controller.
- Sits between the redundant cores' writeback ports and the shared register file.

Parameters:
- NUM_CORES, 3, redundant core count; only 2 or 3 legal, any other value is an elaboration error.
- ADDR_WIDTH, 5, register address width.
- DATA_WIDTH, 32, writeback data width.
- CNT_WIDTH, 8, width of saturating error counters.
- FAULT_THRESHOLD, 3, per-core fault count that triggers recovery; legal range 1..2^CNT_WIDTH-1.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  synchronous active-low reset.
- valid_instr_i  in  1  writeback tuples valid this cycle; all cores in lockstep.
- we_i  in  NUM_CORES  per-core write enable.
- addr_i  in  NUM_CORES*ADDR_WIDTH  per-core address; core k at slice [k*ADDR_WIDTH +: ADDR_WIDTH].
- data_i  in  NUM_CORES*DATA_WIDTH  per-core data; core k at slice [k*DATA_WIDTH +: DATA_WIDTH].
- inject_i  in  1  debug: XOR data bit 0 of core 0 before compare.
- clear_i  in  1  clears all error counters.
- recover_ack_i  in  1  controller accepted the recovery request.
- recover_done_i  in  1  controller finished resynchronising the cores.
- valid_o  out  1  registered tuple valid.
- we_o  out  1  registered agreed write enable.
- addr_o  out  ADDR_WIDTH  registered agreed address.
- data_o  out  DATA_WIDTH  registered agreed data.
- error_o  out  1  one-cycle pulse, mismatch detected.
- faulty_o  out  NUM_CORES  one-hot minority core for a correctable TMR mismatch; 0 otherwise.
- uncorrectable_o  out  1  one-cycle pulse, no majority.
- err_count_o  out  CNT_WIDTH  saturating total mismatch count.
- recover_req_o  out  1  recovery request, level.
- halted_o  out  1  high in any state other than RUN.

Behaviour:
- Reset (rst_ni=0 at posedge):
  - All outputs 0, all counters 0, state RUN.
  - Takes effect mid-REQ/RECOVER as well, returning to RUN and dropping recover_req_o.
- Latency: one cycle. Inputs sampled at edge N appear on outputs after edge N.
- Compare is combinational on full tuples (we, addr, data) after inject_i is applied.
- The valid/we/addr/data output registers hold their value when not loaded; the error pulses return to 0.
- DMR, tuples equal: pass core 0. Sets valid_o=1 and we/addr/data_o from core 0.
- DMR, tuples differ: valid_o=0, error_o=1, uncorrectable_o=1.
- TMR, all equal: pass core 0.
- TMR, exactly one core k differs:
  - Pass the majority tuple with valid_o=1.
  - Pulse error_o=1, with faulty_o bit k set for that cycle.
  - Increment fault_cnt[k] (saturating).
- TMR, all three differ: valid_o=0, error_o=1, uncorrectable_o=1.
- valid_instr_i=0: no compare, valid_o=0, no counting.
- err_count_o: +1 per mismatch event, saturates at all-ones and does not wrap. fault_cnt[k] saturates the same way.
- clear_i:
  - Zeroes err_count_o and all fault_cnt.
  - If a mismatch occurs in the same cycle, the counters end at 1 (clear, then count).
  - Does not affect the FSM.
- FSM (encoding in package):
  - RUN -> REQ on uncorrectable mismatch, or when any fault_cnt reaches FAULT_THRESHOLD on this update.
  - REQ: recover_req_o=1, halted_o=1, valid_o=0, inputs ignored. Goes to RECOVER when recover_ack_i=1 at a clock edge.
  - RECOVER: recover_req_o=0, halted_o=1, valid_o=0. Goes to RUN on recover_done_i=1 and clears all fault_cnt; err_count_o is kept.
  - recover_done_i outside RECOVER and recover_ack_i outside REQ are ignored.
  - The triggering cycle's error_o/uncorrectable_o pulse is still emitted. For a TMR threshold trigger that cycle's majority output is also emitted; recover_req_o rises the next cycle.

Decomposition:
- ft_pkg holds:
  - typedef enum ft_state_e {FT_RUN, FT_REQ, FT_RECOVER}.
  - typedef enum vote_res_e {VOTE_OK, VOTE_CORRECTED, VOTE_FAIL}.
  - Localparams: legal NUM_CORES values.
- Sub-module ft_majority_voter:
  - Purely combinational, parametrised by NUM_CORES and tuple width.
  - Outputs: vote_res, selected tuple, minority one-hot.
- ft_wb_voter adds the output registers, counters and FSM.

Test Plan:
- TMR, all cores {1,5'h03,32'hDEADBEEF}, valid -> next cycle valid_o=1, addr_o=3, data_o=DEADBEEF, error_o=0.
- TMR, core 1 data 32'hDEADBEEE -> data_o=DEADBEEF, error_o=1, faulty_o=3'b010, err_count_o=1. Repeat 3x -> recover_req_o=1 the cycle after the 3rd; ack -> RECOVER; done -> RUN, halted_o=0.
- DMR, addr 5'h01 vs 5'h02 -> valid_o=0, uncorrectable_o=1, next cycle recover_req_o=1 held until recover_ack_i.
- TMR, inject_i=1 with equal inputs 32'h0 -> faulty_o=3'b001, data_o=0.
- CNT_WIDTH=2, 4 corrected faults on different cores with clear_i asserted on the 4th -> err_count_o=1. Then 5 faults with no clear -> saturates at 3.
- rst_ni=0 while in REQ -> next cycle recover_req_o=0, halted_o=0, err_count_o=0, all outputs 0.
